duo_color_decoder: RTL and testbench
====================================

// Module: duo_color_decoder
// PURPOSE
//  Receives the 8-bit duo-colour byte stream ({hi,lo} nibbles, lo == ~hi) and recovers its phase.
//  The stream is a 32-step triangle: hi=0..15, 15..0, repeat, with endpoint samples repeated.
//  Locks a 5-bit phase counter p to the stream, flags mismatches and counts errors.
//  Expands each sample to RGB565 for the OLED pixel path. Sits between the colour source and the OLED driver.
// PARAMETERS
//  LOCK_CNT  4  consecutive consistent candidate phases required to enter TRACK (1..15)
//  MISS_MAX  2  consecutive mismatches in TRACK that drop back to SEARCH (1..15)
//  ERR_W     8  width of err_count
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  duo_valid    in   1      qualifies duo; cycles with duo_valid=0 change no state and emit no pixel
//  duo          in   8      [7:4]=hi nibble, [3:0]=lo nibble
//  pixel_data   out  16     RGB565 of last accepted sample (registered)
//  pixel_valid  out  1      1 for one cycle per accepted sample
//  locked       out  1      1 while FSM in TRACK
//  flip_est     out  1      p[4] in TRACK (1 = hi descending), 0 in SEARCH
//  wrap_pulse   out  1      1-cycle pulse when the tracked phase advances to p=0
//  err_count    out  ERR_W  saturating count of TRACK mismatches
// BEHAVIOUR
//  - Phase map: hi(p) = p[4] ? ~p[3:0] : p[3:0]; expected byte E(p) = {hi(p), ~hi(p)}; p wraps 31->0.
//  - Reset (async, rst_n=0): state=SEARCH, p=0, run=0, miss=0, prev_ok=0, err_count=0, and all outputs 0.
//  - Well-formed sample: duo[3:0] == ~duo[7:4]. prev holds the last accepted sample. prev_ok = prev is well-formed.
//  - SEARCH candidate from the pair (prev, cur), both well-formed:
//      cur.hi == prev.hi+1                  -> c = {0, cur.hi}
//      cur.hi == prev.hi-1                  -> c = {1, ~cur.hi}
//      equal and hi == 15                   -> c = 16
//      equal and hi == 0                    -> c = 0
//      otherwise (incl. 4-bit wrap 15->0 or 0->15) -> no candidate; run = 0.
//    If run > 0 and c == p+1, then run++. Otherwise run = 1. In both cases p = c.
//    When run reaches LOCK_CNT, enter TRACK with miss=0.
//  - TRACK: on each accepted sample, p = p+1 unconditionally (flywheel).
//    Match (duo == E(p+1)): miss = 0.
//    Mismatch: miss++ and err_count++ (saturates at all-ones).
//    When miss reaches MISS_MAX: go to SEARCH with run=0; the current sample becomes prev.
//  - wrap_pulse: asserted in the cycle after an accepted TRACK sample whose new p == 0.
//  - Pixel path: R5 = {hi, hi[3]}, G6 = {lo, lo[3:2]}, B5 = locked-next ? 5'h00 : 5'h1F.
//    Latency is 1 clk: pixel_valid/pixel_data update on the edge after the duo_valid sample.
//    locked, flip_est and B5 all reflect the state after that sample.
//  - Simultaneous: the lock-entering sample and its pixel appear in the same cycle, with B5 = 0.
//    The unlocking sample has B5 = 1F.
//  - Reset mid-stream: everything is lost. Re-lock needs LOCK_CNT+1 fresh samples.
// CONFIGURATION
//  DUO_DEC_CONCEAL_EN defined:
//    On a TRACK mismatch that does not unlock, pixel_data is built from E(p+1) instead of duo.
//  DUO_DEC_CONCEAL_EN undefined: pixel_data is always built from the received duo.
//  FSM, counters and err_count are identical either way.
// TESTING
//  - Reset: with rst_n=0 mid-run, all outputs read 0 immediately (no clock needed) and err_count=0.
//  - Lock: feed 0F,1E,2D,3C,4B back-to-back.
//    locked=0 through 4th pixel (0x3C -> pixel_data=0x367F); locked=1 with 5th pixel; flip_est=0.
//  - Turnaround: continue from lock to E1,F0,F0,E1.
//    flip_est goes 1 on the second F0 (p=16). Continue down to 0F,0F: wrap_pulse on the second 0F.
//    No errors.
//  - Single error: in TRACK, replace one 0x5A with 0x77. err_count=1, locked stays 1, next sample matches.
//    With DUO_DEC_CONCEAL_EN, that pixel comes from 0x5A.
//  - Unlock: two consecutive bad bytes (MISS_MAX=2) -> locked=0, err_count +2.
//    Re-lock needs 4 consistent candidates after a well-formed prev.
//  - Gaps: insert 3 idle cycles (duo_valid=0) between every sample.
//    Same lock point counted in samples; pixel_valid only follows valid cycles.

Source files
------------

// File: rtl/duo_color_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : duo_color_decoder
// Purpose  : Recovers the 32-step triangle phase of a duo-colour byte stream,
//            tracks it with a flywheel, counts mismatches and emits RGB565.
//            Optional macro DUO_DEC_CONCEAL_EN: mismatching TRACK samples that
//            do not unlock are replaced by the expected byte on the pixel path.
// Revision : 1.0  initial release
// ============================================================================
module duo_color_decoder #(
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             duo_valid,
    input  logic [7:0]       duo,
    output logic [15:0]      pixel_data,
    output logic             pixel_valid,
    output logic             locked,
    output logic             flip_est,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_TRACK  = 1'b1
    } state_t;

    localparam logic [3:0]       C_LOCK_CNT = 4'(LOCK_CNT);
    localparam logic [3:0]       C_MISS_MAX = 4'(MISS_MAX);
    localparam logic [ERR_W-1:0] C_ERR_ONE  = ERR_W'(1);

    state_t           state_q, state_d;
    logic [4:0]       p_q, p_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic [7:0]       prev_q, prev_d;
    logic             prev_ok_q, prev_ok_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [15:0]      pix_q, pix_d;
    logic             pix_vld_q, pix_vld_d;
    logic             locked_q, locked_d;
    logic             flip_q, flip_d;
    logic             wrap_q, wrap_d;

    logic [3:0] w_cur_hi;
    logic [3:0] w_prev_hi;
    logic       w_cur_wf;
    logic       w_up;
    logic       w_down;
    logic       w_top;
    logic       w_bot;
    logic       w_cand_vld;
    logic [4:0] w_cand;
    logic [4:0] w_p_inc;
    logic [7:0] w_exp;
    logic       w_match;
    logic [7:0] w_pix_src;

    function automatic logic [7:0] exp_byte(input logic [4:0] ph);
        logic [3:0] h;
        h = ph[4] ? ~ph[3:0] : ph[3:0];
        return {h, ~h};
    endfunction

    assign w_cur_hi  = duo[7:4];
    assign w_prev_hi = prev_q[7:4];
    assign w_cur_wf  = (duo[3:0] == ~duo[7:4]);

    // 5-bit comparisons so that a 15->0 or 0->15 jump never looks adjacent
    assign w_up   = ({1'b0, w_cur_hi} == ({1'b0, w_prev_hi} + 5'd1));
    assign w_down = (({1'b0, w_cur_hi} + 5'd1) == {1'b0, w_prev_hi});
    assign w_top  = (w_cur_hi == w_prev_hi) && (w_cur_hi == 4'hF);
    assign w_bot  = (w_cur_hi == w_prev_hi) && (w_cur_hi == 4'h0);

    assign w_cand_vld = w_cur_wf && prev_ok_q && (w_up || w_down || w_top || w_bot);

    always_comb begin
        w_cand = 5'd0;
        if (w_up) begin
            w_cand = {1'b0, w_cur_hi};
        end else if (w_down) begin
            w_cand = {1'b1, ~w_cur_hi};
        end else if (w_top) begin
            w_cand = 5'd16;
        end else begin
            w_cand = 5'd0;
        end
    end

    assign w_p_inc = p_q + 5'd1;
    assign w_exp   = exp_byte(w_p_inc);
    assign w_match = (duo == w_exp);

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        run_d     = run_q;
        miss_d    = miss_q;
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        err_d     = err_q;
        wrap_d    = 1'b0;
        w_pix_src = duo;

        if (duo_valid) begin
            prev_d    = duo;
            prev_ok_d = w_cur_wf;

            if (state_q == ST_SEARCH) begin
                if (!w_cand_vld) begin
                    run_d = 4'd0;
                end else begin
                    if ((run_q != 4'd0) && (w_cand == w_p_inc)) begin
                        run_d = run_q + 4'd1;
                    end else begin
                        run_d = 4'd1;
                    end
                    p_d = w_cand;
                    if (run_d == C_LOCK_CNT) begin
                        state_d = ST_TRACK;
                        miss_d  = 4'd0;
                    end
                end
            end else begin
                // flywheel: phase advances whether or not the sample agrees
                p_d    = w_p_inc;
                wrap_d = (w_p_inc == 5'd0);
                if (w_match) begin
                    miss_d = 4'd0;
                end else begin
                    miss_d = miss_q + 4'd1;
                    if (err_q != '1) begin
                        err_d = err_q + C_ERR_ONE;
                    end
                    if (miss_d == C_MISS_MAX) begin
                        state_d = ST_SEARCH;
                        run_d   = 4'd0;
                    end
`ifdef DUO_DEC_CONCEAL_EN
                    else begin
                        w_pix_src = w_exp;
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        pix_vld_d = duo_valid;
        locked_d  = (state_d == ST_TRACK);
        flip_d    = (state_d == ST_TRACK) && p_d[4];
        pix_d     = pix_q;
        if (duo_valid) begin
            pix_d = {w_pix_src[7:4], w_pix_src[7],
                     w_pix_src[3:0], w_pix_src[3:2],
                     (state_d == ST_TRACK) ? 5'h00 : 5'h1F};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            p_q       <= 5'd0;
            run_q     <= 4'd0;
            miss_q    <= 4'd0;
            prev_q    <= 8'd0;
            prev_ok_q <= 1'b0;
            err_q     <= '0;
            pix_q     <= 16'd0;
            pix_vld_q <= 1'b0;
            locked_q  <= 1'b0;
            flip_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            run_q     <= run_d;
            miss_q    <= miss_d;
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
            err_q     <= err_d;
            pix_q     <= pix_d;
            pix_vld_q <= pix_vld_d;
            locked_q  <= locked_d;
            flip_q    <= flip_d;
            wrap_q    <= wrap_d;
        end
    end

    assign pixel_data  = pix_q;
    assign pixel_valid = pix_vld_q;
    assign locked      = locked_q;
    assign flip_est    = flip_q;
    assign wrap_pulse  = wrap_q;
    assign err_count   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_duo_color_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_duo_color_decoder
// Purpose  : Self-checking bench for duo_color_decoder against a phase-search
//            reference model of the triangle stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_duo_color_decoder;

    localparam int LOCK_CNT = 4;
    localparam int MISS_MAX = 2;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             duo_valid;
    logic [7:0]       duo;
    logic [15:0]      pixel_data;
    logic             pixel_valid;
    logic             locked;
    logic             flip_est;
    logic             wrap_pulse;
    logic [ERR_W-1:0] err_count;

    duo_color_decoder #(
        .LOCK_CNT (LOCK_CNT),
        .MISS_MAX (MISS_MAX),
        .ERR_W    (ERR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .duo_valid   (duo_valid),
        .duo         (duo),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .locked      (locked),
        .flip_est    (flip_est),
        .wrap_pulse  (wrap_pulse),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_locked, m_phase, m_run, m_miss, m_err, m_prev;
    logic [15:0] x_pix;
    logic        x_wrap;
    int          g_pos;

    wire [ERR_W+19:0] obs = {pixel_valid, pixel_data, locked, flip_est, wrap_pulse, err_count};

    // triangle sample at position p: hi climbs 0..15 then falls 15..0
    function automatic logic [7:0] tri_byte(input int p);
        int         q;
        int         h;
        logic [3:0] n;
        q = p % 32;
        h = (q < 16) ? q : 31 - q;
        n = h[3:0];
        return {n, ~n};
    endfunction

    // the unique phase whose previous and current samples equal (prev, cur)
    function automatic int cand(input int prev, input logic [7:0] cur);
        for (int p = 0; p < 32; p++) begin
            if (prev >= 0 && tri_byte((p + 31) % 32) == prev[7:0] && tri_byte(p) == cur)
                return p;
        end
        return -1;
    endfunction

    function automatic logic [ERR_W+19:0] exp_vec(input logic vld);
        logic [ERR_W-1:0] e;
        logic             lk;
        logic             fl;
        e  = m_err[ERR_W-1:0];
        lk = (m_locked != 0);
        fl = lk && (m_phase >= 16);
        return {vld, x_pix, lk, fl, vld & x_wrap, e};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_phase = 0; m_run = 0; m_miss = 0; m_err = 0; m_prev = -1;
        x_pix = 16'h0000; x_wrap = 1'b0; g_pos = 0;
    endtask

    task automatic model_step(input logic [7:0] b);
        logic [7:0] src;
        int         c;
        src    = b;
        x_wrap = 1'b0;
        if (m_locked == 0) begin
            c = cand(m_prev, b);
            if (c < 0) begin
                m_run = 0;
            end else begin
                m_run   = (m_run > 0 && c == (m_phase + 1) % 32) ? m_run + 1 : 1;
                m_phase = c;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1;
                    m_miss   = 0;
                end
            end
        end else begin
            m_phase = (m_phase + 1) % 32;
            x_wrap  = (m_phase == 0);
            if (b == tri_byte(m_phase)) begin
                m_miss = 0;
            end else begin
                m_miss++;
                if (m_err < ERR_MAX) m_err++;
                if (m_miss == MISS_MAX) begin
                    m_locked = 0;
                    m_run    = 0;
                end
`ifdef DUO_DEC_CONCEAL_EN
                else begin
                    src = tri_byte(m_phase);
                end
`endif
            end
        end
        m_prev = b;
        x_pix  = {src[7:4], src[7], src[3:0], src[3:2], (m_locked != 0) ? 5'h00 : 5'h1F};
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        duo_valid = 1'b1;
        duo       = b;
        @(posedge clk);
        model_step(b);
        #1;
        duo_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        duo_valid = 1'b0;
        duo       = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", obs);
        end
        for (int i = 0; i < 6; i++) send(tri_byte(g_pos++));
        send(8'h77);
        checks++;
        if (err_count !== 8'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset err=%0d locked=%b exp err=1 locked=1", err_count, locked);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_lock();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            send(tri_byte(g_pos++));
            checks++;
            if (obs !== exp_vec(1'b1)) begin
                failures++;
                $display("FAIL lock[%0d] got=%h exp=%h", i, obs, exp_vec(1'b1));
            end
            if (i == 3) begin
                checks++;
                if (pixel_data !== 16'h367F || locked !== 1'b0) begin
                    failures++;
                    $display("FAIL lock_4th pix=%h locked=%b exp pix=367f locked=0", pixel_data, locked);
                end
            end
            if (i == 4) begin
                checks++;
                if (locked !== 1'b1 || flip_est !== 1'b0 || pixel_data[4:0] !== 5'h00) begin
                    failures++;
                    $display("FAIL lock_5th locked=%b flip=%b b5=%h exp 1 0 00", locked, flip_est, pixel_data[4:0]);
                end
            end
        end
    endtask

    task automatic test_turnaround();
        apply_reset();
        for (int i = 0; i <= 32; i++) begin
            send(tri_byte(g_pos++));
            checks++;
            if (obs !== exp_vec(1'b1)) begin
                failures++;
                $display("FAIL turn[%0d] got=%h exp=%h", i, obs, exp_vec(1'b1));
            end
            if (i == 15 || i == 16) begin
                checks++;
                if (flip_est !== (i == 16)) begin
                    failures++;
                    $display("FAIL turn_flip[%0d] got=%b exp=%b", i, flip_est, (i == 16));
                end
            end
            if (i == 31 || i == 32) begin
                checks++;
                if (wrap_pulse !== (i == 32)) begin
                    failures++;
                    $display("FAIL turn_wrap[%0d] got=%b exp=%b", i, wrap_pulse, (i == 32));
                end
            end
        end
        checks++;
        if (err_count !== 8'd0) begin
            failures++;
            $display("FAIL turn_err got=%0d exp=0", err_count);
        end
    endtask

    task automatic test_single_error();
        logic [15:0] want;
`ifdef DUO_DEC_CONCEAL_EN
        want = 16'h5540;
`else
        want = 16'h73A0;
`endif
        apply_reset();
        for (int i = 0; i < 5; i++) send(tri_byte(g_pos++));
        send(8'h77);
        g_pos++;
        checks++;
        if (err_count !== 8'd1 || locked !== 1'b1 || pixel_data !== want) begin
            failures++;
            $display("FAIL single_err err=%0d locked=%b pix=%h exp 1 1 %h", err_count, locked, pixel_data, want);
        end
        send(tri_byte(g_pos++));
        checks++;
        if (obs !== exp_vec(1'b1) || err_count !== 8'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL single_next got=%h exp=%h", obs, exp_vec(1'b1));
        end
    endtask

    task automatic test_unlock();
        apply_reset();
        for (int i = 0; i < 7; i++) send(tri_byte(g_pos++));
        for (int i = 0; i < 2; i++) begin
            send(8'h77);
            g_pos++;
            checks++;
            if (locked !== (i == 0) || err_count !== 8'(i + 1) || pixel_data[4:0] !== ((i == 0) ? 5'h00 : 5'h1F)) begin
                failures++;
                $display("FAIL unlock[%0d] locked=%b err=%0d b5=%h", i, locked, err_count, pixel_data[4:0]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            send(tri_byte(g_pos++));
            checks++;
            if (obs !== exp_vec(1'b1) || locked !== (i == 4)) begin
                failures++;
                $display("FAIL relock[%0d] got=%h exp=%h", i, obs, exp_vec(1'b1));
            end
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            send(tri_byte(g_pos++));
            checks++;
            if (obs !== exp_vec(1'b1) || locked !== (i >= 4)) begin
                failures++;
                $display("FAIL gap_sample[%0d] got=%h exp=%h", i, obs, exp_vec(1'b1));
            end
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                #1;
                checks++;
                if (obs !== exp_vec(1'b0)) begin
                    failures++;
                    $display("FAIL gap_idle[%0d.%0d] got=%h exp=%h", i, k, obs, exp_vec(1'b0));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) g_pos += $urandom_range(1, 20);
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : tri_byte(g_pos);
            g_pos++;
            send(b);
            checks++;
            if (obs !== exp_vec(1'b1)) begin
                failures++;
                $display("FAIL random[%0d] in=%h got=%h exp=%h", i, b, obs, exp_vec(1'b1));
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                checks++;
                if (obs !== exp_vec(1'b0)) begin
                    failures++;
                    $display("FAIL random_idle[%0d] got=%h exp=%h", i, obs, exp_vec(1'b0));
                end
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int r = 0; r < 140; r++) begin
            for (int i = 0; i < 5; i++) send(tri_byte(g_pos++));
            for (int i = 0; i < 2; i++) begin
                send(8'h77);
                g_pos++;
                checks++;
                if (obs !== exp_vec(1'b1)) begin
                    failures++;
                    $display("FAIL sat[%0d.%0d] got=%h exp=%h", r, i, obs, exp_vec(1'b1));
                end
            end
        end
        checks++;
        if (err_count !== 8'hFF) begin
            failures++;
            $display("FAIL sat_final got=%h exp=ff", err_count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        duo_valid = 1'b0;
        duo       = 8'h00;
        model_reset();
        test_reset();
        test_lock();
        test_turnaround();
        test_single_error();
        test_unlock();
        test_gaps();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
